// File: rtl/jk_count_ctrl.sv
// -----------------------------------------------------------------------------
// jk_count_ctrl
//
// A command-driven up/down counter built from WIDTH JK flip-flop cells. The
// controller does not write the count directly. It computes per-bit J/K drives,
// and every cell applies the JK rule to them: 00 hold, 01 clear, 10 set,
// 11 toggle. Loads, clears, count steps and auto-reloads are all expressed as
// J/K patterns.
//
// States:
//   IDLE  accepts commands.
//   RUN   counts toward a limit.
//   DONE  terminal count was reached without reload; accepts commands.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    command can be accepted (high in IDLE and DONE)
//   cmd_op       00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
//   cmd_data     load value (LOAD) or limit (UP/DOWN)
//   en           count enable while in RUN
//   stop         abort the current run (RUN only)
//   auto_reload  sampled at terminal count: 1 reloads the start value and continues
//   j_vec/k_vec  per-bit J/K drive to the counter cells
//   count        current counter value
//   busy         high in RUN
//   done         high in DONE
//   tc_pulse     one-cycle pulse after a terminal count
// -----------------------------------------------------------------------------
module jk_count_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             en,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc_pulse
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] limit_reg, limit_next;
    logic [WIDTH-1:0] start_reg, start_next;
    logic             dir_down_reg, dir_down_next;
    logic             tc_reg, tc_next;

    logic [WIDTH-1:0] up_tgl;    // toggle mask for an increment
    logic [WIDTH-1:0] dn_tgl;    // toggle mask for a decrement
    logic [WIDTH-1:0] j_raw, k_raw;

    logic accept;                // a command is taken on this edge
    logic run_step;              // enabled, non-aborted RUN cycle
    logic at_limit;
    logic terminal;              // run_step at the limit

    assign accept   = cmd_valid && (state_reg != S_RUN);
    assign run_step = (state_reg == S_RUN) && !stop && en;
    assign at_limit = (count_reg == limit_reg);
    assign terminal = run_step && at_limit;

    // Ripple-carry / ripple-borrow toggle masks. Bit i toggles on an increment
    // when all lower bits are 1, and on a decrement when all lower bits are 0.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tgl
            if (gi == 0) begin : g_lsb
                assign up_tgl[gi] = 1'b1;
                assign dn_tgl[gi] = 1'b1;
            end else begin : g_upper
                assign up_tgl[gi] = up_tgl[gi-1] &  count_reg[gi-1];
                assign dn_tgl[gi] = dn_tgl[gi-1] & ~count_reg[gi-1];
            end
        end
    endgenerate

    // JK cells: Q+ = J & ~Q | ~K & Q.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign count_next[gi] = (j_raw[gi] & ~count_reg[gi]) |
                                    (~k_raw[gi] & count_reg[gi]);
        end
    endgenerate

    // State and context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            count_reg    <= '0;
            limit_reg    <= '0;
            start_reg    <= '0;
            dir_down_reg <= 1'b0;
            tc_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            limit_reg    <= limit_next;
            start_reg    <= start_next;
            dir_down_reg <= dir_down_next;
            tc_reg       <= tc_next;
        end
    end

    // Next-state and context capture.
    always_comb begin
        state_next    = state_reg;
        limit_next    = limit_reg;
        start_next    = start_reg;
        dir_down_next = dir_down_reg;
        tc_next       = 1'b0;
        unique case (state_reg)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_UP, OP_DOWN: begin
                            limit_next    = cmd_data;
                            start_next    = count_reg;
                            dir_down_next = (cmd_op == OP_DOWN);
                            state_next    = S_RUN;
                        end
                        default: state_next = S_IDLE;   // LOAD, CLEAR
                    endcase
                end
            end
            S_RUN: begin
                // stop outranks en and terminal count.
                if (stop) begin
                    state_next = S_IDLE;
                end else if (terminal) begin
                    tc_next = 1'b1;
                    if (!auto_reload) begin
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: J/K drive and status decode.
    always_comb begin
        j_raw     = '0;
        k_raw     = '0;
        cmd_ready = (state_reg != S_RUN);
        busy      = (state_reg == S_RUN);
        done      = (state_reg == S_DONE);
        if (accept) begin
            unique case (cmd_op)
                OP_LOAD: begin
                    j_raw = cmd_data;
                    k_raw = ~cmd_data;
                end
                OP_CLEAR: begin
                    j_raw = '0;
                    k_raw = '1;
                end
                default: ;  // UP/DOWN start: count unchanged
            endcase
        end else if (terminal) begin
            if (auto_reload) begin
                j_raw = start_reg;
                k_raw = ~start_reg;
            end
        end else if (run_step) begin
            j_raw = dir_down_reg ? dn_tgl : up_tgl;
            k_raw = j_raw;
        end
    end

    // While reset is held, the cells must see a hold pattern, even though a
    // command may be present on the inputs.
    assign j_vec    = rst_n ? j_raw : '0;
    assign k_vec    = rst_n ? k_raw : '0;
    assign count    = count_reg;
    assign tc_pulse = tc_reg;

endmodule

// File: tb/tb_jk_count_ctrl.sv
module tb_jk_count_ctrl;

    localparam int W = 8;
    localparam int IDLE = 0, RUN = 1, DONE = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         en, stop, auto_reload;
    logic [W-1:0] j_vec, k_vec, count;
    logic         busy, done, tc_pulse;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int           m_state;
    logic [W-1:0] m_count, m_limit, m_start;
    logic         m_down, m_tc;
    int           n_state;
    logic [W-1:0] n_count, n_limit, n_start;
    logic         n_down, n_tc;
    logic [W-1:0] e_j, e_k;

    jk_count_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .en(en), .stop(stop),
        .auto_reload(auto_reload), .j_vec(j_vec), .k_vec(k_vec), .count(count),
        .busy(busy), .done(done), .tc_pulse(tc_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = IDLE; m_count = '0; m_limit = '0; m_start = '0;
        m_down = 1'b0; m_tc = 1'b0;
    endtask

    // Expected next values and J/K drive from the behavioural rules.
    task automatic model_eval();
        int step;
        n_state = m_state; n_count = m_count; n_limit = m_limit;
        n_start = m_start; n_down = m_down; n_tc = 1'b0;
        e_j = '0; e_k = '0;
        if (m_state != RUN && cmd_valid) begin
            case (cmd_op)
                2'd0: begin n_count = cmd_data; e_j = cmd_data; e_k = ~cmd_data; n_state = IDLE; end
                2'd3: begin n_count = '0; e_k = '1; n_state = IDLE; end
                default: begin
                    n_limit = cmd_data; n_start = m_count;
                    n_down = (cmd_op == 2'd2); n_state = RUN;
                end
            endcase
        end else if (m_state == RUN) begin
            if (stop) begin
                n_state = IDLE;
            end else if (en) begin
                if (m_count == m_limit) begin
                    n_tc = 1'b1;
                    if (auto_reload) begin
                        n_count = m_start; e_j = m_start; e_k = ~m_start;
                    end else begin
                        n_state = DONE;
                    end
                end else begin
                    step = m_down ? 255 : 1;   // -1 mod 256
                    n_count = W'((int'(m_count) + step) % 256);
                    e_j = m_count ^ n_count;   // bits that change are toggled
                    e_k = e_j;
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] d,
                         input logic e, input logic s, input logic ar);
        @(negedge clk);
        cmd_valid = v; cmd_op = op; cmd_data = d; en = e; stop = s; auto_reload = ar;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_state = n_state; m_count = n_count; m_limit = n_limit;
        m_start = n_start; m_down = n_down; m_tc = n_tc;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [W-1:0] d);
        drive(1'b1, op, d, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'hA5;
        en = 1'b1; stop = 1'b0; auto_reload = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (j_vec !== 8'h00 || k_vec !== 8'h00) begin n_err++; $display("FAIL reset_jk: j=%h k=%h required 00/00", j_vec, k_vec); end
        n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL reset_count: got %h required 00", count); end
        n_vec++; if ({cmd_ready, busy, done, tc_pulse} !== 4'b1000) begin n_err++; $display("FAIL reset_status: rdy/busy/done/tc=%b required 1000", {cmd_ready, busy, done, tc_pulse}); end
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release must accept a LOAD.
        drive(1'b1, 2'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        n_vec++; if (j_vec !== 8'h5A || k_vec !== 8'hA5) begin n_err++; $display("FAIL load_jk: j=%h k=%h required 5a/a5", j_vec, k_vec); end
        tick();
        n_vec++; if (count !== 8'h5A) begin n_err++; $display("FAIL first_load: got %h required 5a", count); end
    endtask

    task automatic test_up_basic();
        cmd(2'd3, 8'h00);
        cmd(2'd1, 8'd5);
        n_vec++; if (busy !== 1'b1 || count !== 8'd0) begin n_err++; $display("FAIL up_start: busy=%b count=%h required 1/00", busy, count); end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
            tick();
            n_vec++; if (count !== W'(i) || tc_pulse !== 1'b0) begin n_err++; $display("FAIL up_step%0d: count=%h tc=%b required %h/0", i, count, tc_pulse, W'(i)); end
        end
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_vec++; if (j_vec !== 8'h00 || k_vec !== 8'h00) begin n_err++; $display("FAIL up_term_jk: j=%h k=%h required 00/00", j_vec, k_vec); end
        tick();
        n_vec++; if (tc_pulse !== 1'b1 || done !== 1'b1 || count !== 8'd5) begin n_err++; $display("FAIL up_term: tc=%b done=%b count=%h required 1/1/05", tc_pulse, done, count); end
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        n_vec++; if (tc_pulse !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin n_err++; $display("FAIL up_after: tc=%b done=%b rdy=%b required 0/1/1", tc_pulse, done, cmd_ready); end
    endtask

    task automatic test_wrap();
        logic [W-1:0] exp_seq [3];
        int tcs;
        exp_seq[0] = 8'hFF; exp_seq[1] = 8'h00; exp_seq[2] = 8'h01;
        tcs = 0;
        cmd(2'd0, 8'hFE);
        cmd(2'd1, 8'h01);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_vec++; if (j_vec !== e_j || k_vec !== e_k) begin n_err++; $display("FAIL wrap_jk%0d: j=%h k=%h required %h/%h", i, j_vec, k_vec, e_j, e_k); end
            tick();
            if (tc_pulse) tcs++;
            n_vec++; if (count !== exp_seq[i]) begin n_err++; $display("FAIL wrap_step%0d: got %h required %h", i, count, exp_seq[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
            tick();
            if (tc_pulse) tcs++;
        end
        n_vec++; if (tcs != 1 || count !== 8'h01 || done !== 1'b1) begin n_err++; $display("FAIL wrap_tc: pulses=%0d count=%h done=%b required 1/01/1", tcs, count, done); end
    endtask

    task automatic test_reload();
        logic [W-1:0] seq [4];
        seq[0] = 8'd2; seq[1] = 8'd1; seq[2] = 8'd0; seq[3] = 8'd3;
        cmd(2'd0, 8'd3);
        drive(1'b1, 2'd2, 8'd0, 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1);
            if (i % 4 == 3) begin
                n_vec++; if (j_vec !== 8'h03 || k_vec !== 8'hFC) begin n_err++; $display("FAIL reload_jk%0d: j=%h k=%h required 03/fc", i, j_vec, k_vec); end
            end
            tick();
            n_vec++; if (count !== seq[i % 4] || tc_pulse !== (i % 4 == 3) || done !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL reload%0d: count=%h tc=%b done=%b busy=%b required %h/%b/0/1", i, count, tc_pulse, done, busy, seq[i % 4], (i % 4 == 3));
            end
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_en_toggle();
        cmd(2'd3, 8'h00);
        cmd(2'd1, 8'd10);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd0, 8'hAA, (i % 2 == 1), 1'b0, 1'b0);
            tick();
            n_vec++; if (count !== W'((i + 1) / 2) || busy !== 1'b1 || cmd_ready !== 1'b0) begin
                n_err++; $display("FAIL en_toggle%0d: count=%h busy=%b rdy=%b required %h/1/0", i, count, busy, cmd_ready, W'((i + 1) / 2));
            end
        end
        drive(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_stop();
        int tcs;
        tcs = 0;
        cmd(2'd3, 8'h00);
        cmd(2'd1, 8'h80);
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
            tick();
        end
        n_vec++; if (count !== 8'h20) begin n_err++; $display("FAIL stop_pre: got %h required 20", count); end
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1);
        n_vec++; if (j_vec !== 8'h00 || k_vec !== 8'h00) begin n_err++; $display("FAIL stop_jk: j=%h k=%h required 00/00", j_vec, k_vec); end
        tick();
        if (tc_pulse) tcs++;
        drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0);   // stop outside RUN: no effect
        tick();
        if (tc_pulse) tcs++;
        n_vec++; if (count !== 8'h20 || busy !== 1'b0 || done !== 1'b0 || tcs != 0) begin
            n_err++; $display("FAIL stop: count=%h busy=%b done=%b pulses=%0d required 20/0/0/0", count, busy, done, tcs);
        end
        cmd(2'd3, 8'h77);
        n_vec++; if (count !== 8'h00) begin n_err++; $display("FAIL clear: got %h required 00", count); end
    endtask

    task automatic test_async_reset();
        cmd(2'd3, 8'h00);
        cmd(2'd1, 8'h40);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
            tick();
        end
        n_vec++; if (count !== 8'd7) begin n_err++; $display("FAIL areset_pre: got %h required 07", count); end
        @(negedge clk);
        en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        n_vec++; if (count !== 8'h00 || busy !== 1'b0 || cmd_ready !== 1'b1 || j_vec !== 8'h00 || k_vec !== 8'h00) begin
            n_err++; $display("FAIL areset: count=%h busy=%b rdy=%b j=%h k=%h required 00/0/1/00/00", count, busy, cmd_ready, j_vec, k_vec);
        end
        @(posedge clk);
        #1;
        n_vec++; if (tc_pulse !== 1'b0 || count !== 8'h00) begin n_err++; $display("FAIL areset_tc: tc=%b count=%h required 0/00", tc_pulse, count); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic         v, e, s, ar;
        logic [1:0]   op;
        logic [W-1:0] d;
        for (int i = 0; i < 600; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else d = m_count + 8'($urandom_range(0, 6)) - 8'($urandom_range(0, 2));
            e  = ($urandom_range(0, 3) != 0);
            s  = ($urandom_range(0, 39) == 0);
            ar = $urandom_range(0, 1) == 1;
            drive(v, op, d, e, s, ar);
            n_vec++; if (j_vec !== e_j || k_vec !== e_k) begin
                n_err++; $display("FAIL rnd_jk%0d: j=%h k=%h required %h/%h", i, j_vec, k_vec, e_j, e_k);
            end
            tick();
            n_vec++; if (count !== m_count || tc_pulse !== m_tc || busy !== (m_state == RUN) ||
                         done !== (m_state == DONE) || cmd_ready !== (m_state != RUN)) begin
                n_err++; $display("FAIL rnd%0d: count=%h tc=%b busy=%b done=%b rdy=%b required %h/%b/%b/%b/%b",
                    i, count, tc_pulse, busy, done, cmd_ready, m_count, m_tc,
                    (m_state == RUN), (m_state == DONE), (m_state != RUN));
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_basic();
        test_wrap();
        test_reload();
        test_en_toggle();
        test_stop();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jk_count_ctrl.md
JK_COUNT_CTRL -- requirements
Module: jk_count_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of counter bits (JK cells).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command can be accepted; high in IDLE and DONE, low in RUN.
REQ-006 SHALL have port cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
REQ-007 SHALL have port cmd_data  input  WIDTH  load value (LOAD) or limit (UP/DOWN); ignored for CLEAR.
REQ-008 SHALL have port en  input  1  count enable in RUN.
REQ-009 SHALL have port stop  input  1  abort a run.
REQ-010 SHALL have port auto_reload  input  1  sampled at terminal count; 1 means reload and continue.
REQ-011 SHALL have port j_vec  output  WIDTH  per-bit J drive to the counter cells.
REQ-012 SHALL have port k_vec  output  WIDTH  per-bit K drive to the counter cells.
REQ-013 SHALL have port count  output  WIDTH  current counter value.
REQ-014 SHALL have port busy  output  1  high while in RUN.
REQ-015 SHALL have port done  output  1  high while in DONE.
REQ-016 SHALL have port tc_pulse  output  1  one-cycle pulse at terminal count.

Function
REQ-017 SHALL implement states IDLE, RUN, DONE; busy and done are decoded directly from state.
REQ-018 SHALL update each count bit per the JK rule from j_vec/k_vec: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-019 SHALL drive j_vec = k_vec = 0 whenever no update is required.
REQ-020 SHALL accept a command on a rising edge with cmd_valid & cmd_ready.
REQ-021 LOAD (IDLE/DONE): j_vec = cmd_data, k_vec = ~cmd_data; count = cmd_data next cycle; next state IDLE.
REQ-022 CLEAR (IDLE/DONE): j_vec = 0, k_vec = all-ones; count = 0 next cycle; next state IDLE.
REQ-023 UP/DOWN accepted: capture limit = cmd_data, direction, and start = current count; next state RUN; count unchanged on that edge.
REQ-024 RUN, en=1, stop=0, count != limit: count steps by +1 (UP) or -1 (DOWN) modulo 2^WIDTH.
REQ-025 UP step: bit i toggles (j=k=1) iff bits 0..i-1 are all 1; bit 0 always toggles.
REQ-026 DOWN step: bit i toggles (j=k=1) iff bits 0..i-1 are all 0; bit 0 always toggles.
REQ-027 RUN, en=0, stop=0: count holds; no state change.
REQ-028 RUN, en=1, stop=0, count == limit: tc_pulse = 1 for the next cycle only.
REQ-029 At terminal with auto_reload=1: j_vec = start, k_vec = ~start; count = start next cycle; state stays RUN.
REQ-030 At terminal with auto_reload=0: count holds; next state DONE.
REQ-031 If count == limit when RUN is entered, the first enabled cycle is the terminal cycle.
REQ-032 Wrap-around: stepping past all-ones (UP) or zero (DOWN) SHALL wrap and continue toward limit.
REQ-033 stop=1 in RUN has priority over en and terminal: next state IDLE, count holds, no tc_pulse.
REQ-034 stop outside RUN SHALL have no effect.
REQ-035 cmd_valid while cmd_ready=0 SHALL be ignored; no command is queued.

Reset
REQ-036 rst_n low SHALL asynchronously force: state IDLE, count 0, limit 0, start 0, direction UP, tc_pulse 0.
REQ-037 During reset SHALL hold j_vec = k_vec = 0, busy = 0, done = 0, cmd_ready = 1.
REQ-038 Reset asserted mid-RUN SHALL abort the run immediately with no tc_pulse.
REQ-039 The first command SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-040 Reset, then UP limit=5 with en=1 -> count 1..5 on successive cycles; tc_pulse one cycle; then DONE with count=5.
REQ-041 LOAD 0xFE, then UP limit=0x01 with en=1 -> count FF, 00, 01; tc_pulse once; wrap verified.
REQ-042 LOAD 3, then DOWN limit=0 with auto_reload=1 -> count 2,1,0, then 3, repeating; tc_pulse on each reload; done stays 0.
REQ-043 UP limit=10 with en toggling 1/0 -> count advances only on en=1 cycles; cmd_valid in RUN is ignored.
REQ-044 UP limit=0x80, stop=1 at count=0x20 -> IDLE with count=0x20, no tc_pulse; a later CLEAR gives count=0.
REQ-045 rst_n low mid-RUN at count=7 -> count=0, IDLE, j_vec=k_vec=0 without waiting for a clock edge.
